// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready request in, registered result out.
// Single-cycle ops complete in one cycle; MUL runs a one-bit-per-cycle shift-add loop.
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       instruction,
  input  logic [2:0]       ALUOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SLT, OP_LUI, OP_MUL, OP_ILL
  } op_t;

  function automatic op_t decode(input logic [2:0] alu_op, input logic [5:0] funct);
    op_t op;
    case (alu_op)
      3'b000: begin
        case (funct)
          6'h20:   op = OP_ADD;
          6'h22:   op = OP_SUB;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h27:   op = OP_NOR;
          6'h26:   op = OP_XOR;
          6'h2A:   op = OP_SLT;
          6'h18:   op = OP_MUL;
          default: op = OP_ILL;
        endcase
      end
      3'b001:  op = OP_SUB;
      3'b010:  op = OP_ADD;
      3'b011:  op = OP_ADD;
      3'b100:  op = OP_AND;
      3'b101:  op = OP_LUI;
      3'b110:  op = OP_OR;
      default: op = OP_SLT;
    endcase
    return op;
  endfunction

  // MUL and illegal ops both yield zero here; MUL only reaches this path when disabled.
  function automatic logic [WIDTH-1:0] alu(input op_t op, input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    logic [WIDTH-1:0]        r;
    sx = x;
    sy = y;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = (sx < sy) ? WIDTH'(1) : '0;
      OP_LUI:  r = y << (WIDTH / 2);
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  op_t              op;
  logic             accept;
  logic             start_mul;
  logic [WIDTH-1:0] acc_nxt;

  assign op        = decode(ALUOp, instruction);
  assign start_mul = (op == OP_MUL) && (MUL_EN != 0);
  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) state_d = IDLE;
        if (accept) begin
          if (start_mul) begin
            state_d  = MULT;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
          end else begin
            state_d   = DONE;
            result_d  = alu(op, a, b);
            illegal_d = (op == OP_ILL) || (op == OP_MUL);
          end
        end
      end
      MULT: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d   = DONE;
          result_d  = acc_nxt;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
